// File: rtl/det_event_monitor_if.sv
// Bus between the pattern-detector side and the event monitor.
// The slave side is the monitor; the master side drives det/ack and consumes results.
interface det_event_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             det;
  logic             ack;
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] win_count;
  logic             win_valid;
  logic             alarm;
  logic             overrun;

  modport slave (
    input  det, ack,
    output total, win_count, win_valid, alarm, overrun
  );

  modport master (
    output det, ack,
    input  total, win_count, win_valid, alarm, overrun
  );
endinterface

// File: rtl/det_event_monitor.sv
// Event monitor for the detector output: turns det assertions into rising-edge
// events, keeps a saturating lifetime total, counts events per fixed window and
// publishes each window result through a valid/ack handshake with rate alarm
// and sticky overrun flag.
module det_event_monitor #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned WINDOW = 16,
  parameter int unsigned THRESH = 3
) (
  input  logic                clk,
  input  logic                reset,
  det_event_monitor_if.slave  bus
);

  localparam int unsigned      TMR_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESH);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             det_q;
  logic [TMR_W-1:0] tmr;
  logic [CNT_W-1:0] cur;
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] win_count_q;
  logic             alarm_q;
  logic             overrun_q;

  logic             rise;
  logic             wend;
  logic [CNT_W-1:0] cur_inc;
  logic [CNT_W-1:0] total_inc;
  logic             overrun_set;

  // Edge detect, window end and saturating increments of both counters
  always_comb begin
    rise      = bus.det & ~det_q;
    wend      = (tmr == TMR_LAST);
    cur_inc   = (rise && (cur != '1))     ? cur + CNT_W'(1)     : cur;
    total_inc = (rise && (total_q != '1)) ? total_q + CNT_W'(1) : total_q;
  end

  // Handshake next state; an unacknowledged result overwritten at window end sets overrun
  always_comb begin
    state_d     = state_q;
    overrun_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (wend) state_d = VALID;
      end
      VALID: begin
        if (wend) begin
          state_d     = VALID;
          overrun_set = ~bus.ack;
        end else if (bus.ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state registers; reset discards any partial window
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      det_q       <= 1'b0;
      tmr         <= '0;
      cur         <= '0;
      total_q     <= '0;
      win_count_q <= '0;
      alarm_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      det_q   <= bus.det;
      total_q <= total_inc;
      tmr     <= wend ? '0 : tmr + TMR_W'(1);
      if (wend) begin
        // a rise in the final cycle belongs to the window that is ending
        win_count_q <= cur_inc;
        alarm_q     <= (cur_inc >= THR);
        cur         <= '0;
      end else begin
        cur <= cur_inc;
      end
      if (overrun_set) overrun_q <= 1'b1;
    end
  end

  assign bus.total     = total_q;
  assign bus.win_count = win_count_q;
  assign bus.win_valid = (state_q == VALID);
  assign bus.alarm     = alarm_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_det_event_monitor.sv
// Directed bench for det_event_monitor: one instance at default parameters,
// one narrow/long-window instance for saturation and mid-window reset.
module tb_det_event_monitor;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  det_event_monitor_if #(.CNT_W(8)) bus_a ();
  det_event_monitor_if #(.CNT_W(4)) bus_b ();

  det_event_monitor #(.CNT_W(8), .WINDOW(16), .THRESH(3)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  det_event_monitor #(.CNT_W(4), .WINDOW(64), .THRESH(3)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag,
                            input logic [7:0] tot, input logic [7:0] wc,
                            input logic v, input logic a, input logic o,
                            input int unsigned e_tot, input int unsigned e_wc,
                            input logic e_v, input logic e_a, input logic e_o);
    check({tag, ".total"},     32'(tot), e_tot);
    check({tag, ".win_count"}, 32'(wc),  e_wc);
    check({tag, ".win_valid"}, 32'(v),   32'(e_v));
    check({tag, ".alarm"},     32'(a),   32'(e_a));
    check({tag, ".overrun"},   32'(o),   32'(e_o));
  endtask

  task automatic outs_a(input string tag, input int unsigned e_tot, input int unsigned e_wc,
                        input logic e_v, input logic e_a, input logic e_o);
    check_outs(tag, bus_a.total, bus_a.win_count, bus_a.win_valid, bus_a.alarm,
               bus_a.overrun, e_tot, e_wc, e_v, e_a, e_o);
  endtask

  task automatic outs_b(input string tag, input int unsigned e_tot, input int unsigned e_wc,
                        input logic e_v, input logic e_a, input logic e_o);
    check_outs(tag, 8'(bus_b.total), 8'(bus_b.win_count), bus_b.win_valid, bus_b.alarm,
               bus_b.overrun, e_tot, e_wc, e_v, e_a, e_o);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive DUT A for window cycles first..last, det/ack taken from bit [tmr]
  task automatic run_a(input logic [15:0] det_pat, input logic [15:0] ack_pat,
                       input int unsigned first, input int unsigned last);
    for (int unsigned t = first; t <= last; t++) begin
      bus_a.det = det_pat[t];
      bus_a.ack = ack_pat[t];
      tick();
    end
    bus_a.ack = 1'b0;
  endtask

  task automatic run_b(input logic [63:0] det_pat, input int unsigned first,
                       input int unsigned last);
    for (int unsigned t = first; t <= last; t++) begin
      bus_b.det = det_pat[t];
      tick();
    end
  endtask

  logic [63:0] pat;

  initial begin
    rst_a     = 1'b1;
    rst_b     = 1'b1;
    bus_a.det = 1'b1;
    bus_a.ack = 1'b0;
    bus_b.det = 1'b0;
    bus_b.ack = 1'b0;

    // reset with det high: outputs stay zero during and one cycle after
    tick();
    outs_a("rst1", 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    outs_a("rst2", 0, 0, 1'b0, 1'b0, 1'b0);
    rst_a = 1'b0;
    outs_a("post_rst", 0, 0, 1'b0, 1'b0, 1'b0);

    // level held high is one event; first post-reset cycle counts as rise
    run_a(16'h07FF, 16'h0000, 0, 0);
    outs_a("first_rise", 1, 0, 1'b0, 1'b0, 1'b0);
    run_a(16'h07FF, 16'h0000, 1, 14);
    check("pre_wend.valid", 32'(bus_a.win_valid), 0);
    run_a(16'h07FF, 16'h0000, 15, 15);
    outs_a("level", 1, 1, 1'b1, 1'b0, 1'b0);

    // toggling det: 8 rises in a window raises alarm
    run_a(16'h5555, 16'h0001, 0, 0);
    check("ack_clear.valid", 32'(bus_a.win_valid), 0);
    run_a(16'h5555, 16'h0001, 1, 15);
    outs_a("rate", 9, 8, 1'b1, 1'b1, 1'b0);

    // quiet window drops alarm
    run_a(16'h0000, 16'h0001, 0, 15);
    outs_a("quiet", 9, 0, 1'b1, 1'b0, 1'b0);

    // ack exactly at window end while valid: new result, no overrun
    run_a(16'h0055, 16'h8000, 0, 15);
    outs_a("ack_wend", 13, 4, 1'b1, 1'b1, 1'b0);

    // two unacknowledged windows: second overwrites first
    run_a(16'h0014, 16'h0001, 0, 15);
    outs_a("ovr_w1", 15, 2, 1'b1, 1'b0, 1'b0);
    run_a(16'h02AA, 16'h0000, 0, 15);
    outs_a("ovr_w2", 20, 5, 1'b1, 1'b1, 1'b1);
    run_a(16'h0000, 16'h0001, 0, 0);
    outs_a("ovr_ack", 20, 5, 1'b0, 1'b1, 1'b1);

    // narrow counters: saturation, rise in wend cycle, mid-window reset
    rst_b = 1'b0;
    pat = '0;
    for (int unsigned i = 0; i < 19; i++) pat[2*i] = 1'b1;
    pat[63] = 1'b1;
    run_b(pat, 0, 40);
    check("sat_mid.total", 32'(bus_b.total), 15);
    run_b(pat, 41, 63);
    outs_b("sat", 15, 15, 1'b1, 1'b1, 1'b0);

    pat = '0;
    pat[10] = 1'b1;
    pat[12] = 1'b1;
    pat[63] = 1'b1;
    run_b(pat, 0, 63);
    outs_b("wend_rise", 15, 3, 1'b1, 1'b1, 1'b1);

    pat = '0;
    pat[0] = 1'b1;
    run_b(pat, 0, 63);
    outs_b("no_carry", 15, 0, 1'b1, 1'b0, 1'b1);

    pat = '0;
    run_b(pat, 0, 6);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    outs_b("mid_rst", 0, 0, 1'b0, 1'b0, 1'b0);

    pat = '0;
    pat[0] = 1'b1;
    pat[5] = 1'b1;
    run_b(pat, 0, 62);
    outs_b("full_win_pre", 2, 0, 1'b0, 1'b0, 1'b0);
    run_b(pat, 63, 63);
    outs_b("full_win", 2, 2, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
